cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Bridges the cache's line-wide port (one 256-bit line per transfer) and the physical memory burst port (64-bit beats).
- On a line read, it collects four memory beats into a line for the cache data array to fill.
- On a line write, it breaks an evicted line into four beats for memory.
- Sits between the cache controller/data array and main memory; it is the memory-side counterpart of the array's line write path.

Parameters:
- s_line, 256, cache line width in bits.
- s_burst, 64, memory beat width in bits.
- s_addr, 32, address width.
- s_offset, 5, line offset bits; cleared on address_o.

Ports:
- clk  in  1  clock.
- reset_n  in  1  synchronous active-low reset.
- read_i  in  1  cache requests a line fill.
- write_i  in  1  cache requests a line writeback.
- address_i  in  s_addr  line address from cache.
- line_i  in  s_line  line to write back.
- line_o  out  s_line  assembled fill line.
- resp_o  out  1  one-cycle done pulse to cache.
- burst_i  in  s_burst  read beat from memory.
- burst_o  out  s_burst  write beat to memory.
- address_o  out  s_addr  line-aligned address to memory.
- read_o  out  1  memory burst read request.
- write_o  out  1  memory burst write request.
- resp_i  in  1  memory beat accepted/valid.

Behaviour:
- Beats per line: NB = s_line/s_burst = 4. Beat counter is 2 bits; beat k occupies bits [64k +: 64]. Beat 0 is the least significant.
- Reset (reset_n low at posedge):
  - State goes to IDLE.
  - read_o, write_o and resp_o go to 0.
  - Counter, address_o, burst_o and line_o go to 0.
  - Reset applied mid-burst abandons the transfer with no resp_o; memory is expected to be reset alongside.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - On write_i (priority over read_i when both are high): latch line_i, and latch address_i with its low s_offset bits cleared into address_o. Counter=0, write_o=1, burst_o=line_i[63:0]. Go to WRITE.
  - Else on read_i: latch the aligned address, counter=0, read_o=1. Go to READ.
- READ:
  - Each cycle resp_i=1: line_o[64*cnt +: 64] <= burst_i, and the counter increments.
  - On the beat where cnt==3: read_o<=0. Go to DONE.
  - resp_i=0 cycles are stalls with no state change; gaps between beats are legal.
- WRITE:
  - burst_o always shows line beat cnt.
  - Each cycle resp_i=1: the counter increments and burst_o advances to the next beat.
  - On the cnt==3 beat: write_o<=0. Go to DONE.
- DONE:
  - resp_o=1 for exactly one cycle. Return to IDLE.
  - line_o is stable from the resp_o cycle until the next read's first beat.
- read_i/write_i are ignored outside IDLE.
  - The cache holds its request until it sees resp_o; a request still high in the IDLE cycle after DONE starts a new transfer. The cache must drop it in the resp_o cycle.
- Latency:
  - Request sampled at edge 0; read_o/write_o are high from cycle 1.
  - With beats on consecutive cycles from cycle 1, resp_o is high in cycle 5.
- address_o is constant for the whole burst; memory increments the beat address internally.
- All outputs are registered; no combinational paths from inputs to outputs.

Decomposition:
- Shared cache package holds:
  - Localparams s_line, s_burst, NB, s_offset.
  - The state enum (IDLE, READ, WRITE, DONE).
  - A beat-index typedef, logic [$clog2(NB)-1:0].
- The package is reused by cache control and data array instances.
- No sub-module; the FSM, counter, and line shift/insert logic sit in one module (~150 lines).

Test Plan:
- Fill, back-to-back beats: read_i with address_i=0x0000_1234; memory returns 0x11..11, 0x22..22, 0x33..33, 0x44..44 on cycles 1–4 → address_o=0x0000_1220, read_o high cycles 1–4, resp_o in cycle 5, line_o=0x44..44_33..33_22..22_11..11.
- Writeback with stalls: line_i=0xDDDD..._CCCC..._BBBB..._AAAA..., resp_i pattern 1,0,0,1,1,0,1 → burst_o sequence A,B,B,B,C,D,D; write_o drops after the 4th accepted beat; single resp_o pulse.
- Simultaneous read_i=write_i=1 in IDLE → write burst runs first (write_o=1, read_o=0); read starts only after resp_o if read_i is still held.
- Reset mid-fill: reset_n low after beat 2 → next cycle read_o=0, resp_o=0, line_o=0, state IDLE; a new read completes normally.
- Request held through DONE: read_i held high → no second transfer begins before resp_o. Dropping read_i in the resp_o cycle → IDLE persists with read_o=0.

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
// Shared cache types: line/beat geometry, adaptor state encoding and beat index.
package cacheline_adaptor_pkg;
  localparam int s_line   = 256;
  localparam int s_burst  = 64;
  localparam int s_addr   = 32;
  localparam int s_offset = 5;
  localparam int NB       = s_line / s_burst;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [$clog2(NB)-1:0] beat_idx_t;
endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side line port plus memory-side burst port; slave is the adaptor's view.
interface cacheline_adaptor_if;
  import cacheline_adaptor_pkg::*;

  logic                read_i;
  logic                write_i;
  logic [s_addr-1:0]   address_i;
  logic [s_line-1:0]   line_i;
  logic [s_line-1:0]   line_o;
  logic                resp_o;
  logic [s_burst-1:0]  burst_i;
  logic [s_burst-1:0]  burst_o;
  logic [s_addr-1:0]   address_o;
  logic                read_o;
  logic                write_o;
  logic                resp_i;

  modport slave (
    input  read_i, write_i, address_i, line_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output read_i, write_i, address_i, line_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_adaptor.sv
// Line <-> 4-beat burst bridge; request to read_o/write_o is 1 cycle, resp_o one cycle after the 4th beat.
// resp_i low stalls the burst indefinitely; write_i wins over read_i; all outputs registered.
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  cacheline_adaptor_if.slave  bus
);

  state_t              r_state, w_state_nxt;
  beat_idx_t           r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [s_line-1:0]   r_line_buf, w_line_buf_nxt;
  logic [s_line-1:0]   r_line_o, w_line_o_nxt;
  logic [s_burst-1:0]  r_burst_o, w_burst_o_nxt;
  logic [s_addr-1:0]   r_addr_o, w_addr_o_nxt;
  logic                r_read_o, w_read_o_nxt;
  logic                r_write_o, w_write_o_nxt;
  logic                r_resp_o, w_resp_o_nxt;
  logic                w_last_beat;
  logic [s_addr-1:0]   w_addr_aligned;
  logic                w_unused_addr_lsbs;

  assign w_cnt_inc          = r_cnt + 1'b1;
  assign w_last_beat        = bus.resp_i && (r_cnt == beat_idx_t'(NB - 1));
  assign w_addr_aligned     = {bus.address_i[s_addr-1:s_offset], {s_offset{1'b0}}};
  assign w_unused_addr_lsbs = ^bus.address_i[s_offset-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.write_i)     w_state_nxt = WRITE;
        else if (bus.read_i) w_state_nxt = READ;
      end
      READ, WRITE: if (w_last_beat) w_state_nxt = DONE;
      DONE:        w_state_nxt = IDLE;
      default:     w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_line_buf_nxt = r_line_buf;
    w_line_o_nxt   = r_line_o;
    w_burst_o_nxt  = r_burst_o;
    w_addr_o_nxt   = r_addr_o;
    w_read_o_nxt   = r_read_o;
    w_write_o_nxt  = r_write_o;
    w_resp_o_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.write_i) begin
          w_line_buf_nxt = bus.line_i;
          w_addr_o_nxt   = w_addr_aligned;
          w_cnt_nxt      = '0;
          w_write_o_nxt  = 1'b1;
          w_burst_o_nxt  = bus.line_i[s_burst-1:0];
        end else if (bus.read_i) begin
          w_addr_o_nxt   = w_addr_aligned;
          w_cnt_nxt      = '0;
          w_read_o_nxt   = 1'b1;
        end
      end
      READ: begin
        if (bus.resp_i) begin
          w_line_o_nxt[int'(r_cnt) * s_burst +: s_burst] = bus.burst_i;
          w_cnt_nxt = w_cnt_inc;
          if (w_last_beat) begin
            w_read_o_nxt = 1'b0;
            w_resp_o_nxt = 1'b1;
          end
        end
      end
      WRITE: begin
        // burst_o is pre-loaded with the following beat so memory never sees a bubble
        if (bus.resp_i) begin
          w_cnt_nxt     = w_cnt_inc;
          w_burst_o_nxt = r_line_buf[int'(w_cnt_inc) * s_burst +: s_burst];
          if (w_last_beat) begin
            w_write_o_nxt = 1'b0;
            w_resp_o_nxt  = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt      <= '0;
      r_line_buf <= '0;
      r_line_o   <= '0;
      r_burst_o  <= '0;
      r_addr_o   <= '0;
      r_read_o   <= 1'b0;
      r_write_o  <= 1'b0;
      r_resp_o   <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_line_buf <= w_line_buf_nxt;
      r_line_o   <= w_line_o_nxt;
      r_burst_o  <= w_burst_o_nxt;
      r_addr_o   <= w_addr_o_nxt;
      r_read_o   <= w_read_o_nxt;
      r_write_o  <= w_write_o_nxt;
      r_resp_o   <= w_resp_o_nxt;
    end
  end

  assign bus.line_o    = r_line_o;
  assign bus.resp_o    = r_resp_o;
  assign bus.burst_o   = r_burst_o;
  assign bus.address_o = r_addr_o;
  assign bus.read_o    = r_read_o;
  assign bus.write_o   = r_write_o;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: fill, stalled writeback, priority, mid-burst reset, held request.
module tb_cacheline_adaptor;
  import cacheline_adaptor_pkg::*;

  logic clk;
  logic reset_n;
  int   n_pass;
  int   n_total;

  cacheline_adaptor_if bus();

  cacheline_adaptor dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.address_i = '0;
    bus.line_i    = '0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    tick();
    tick();
    n_total++;
    if ({bus.read_o, bus.write_o, bus.resp_o} !== 3'b000)
      $display("FAIL reset_ctrl: got %b expected 000", {bus.read_o, bus.write_o, bus.resp_o});
    else n_pass++;
    n_total++;
    if (bus.line_o !== 256'd0) $display("FAIL reset_line_o: got %h expected 0", bus.line_o);
    else n_pass++;
    n_total++;
    if ({bus.address_o, bus.burst_o} !== 96'd0)
      $display("FAIL reset_addr_burst: got %h/%h expected 0/0", bus.address_o, bus.burst_o);
    else n_pass++;
    reset_n = 1'b1;
    tick();
    n_total++;
    if ({bus.read_o, bus.write_o} !== 2'b00)
      $display("FAIL reset_idle: got %b expected 00", {bus.read_o, bus.write_o});
    else n_pass++;
  endtask

  task automatic test_fill();
    logic [63:0]  beats [4];
    logic [255:0] exp_line;
    beats[0] = {16{4'h1}};
    beats[1] = {16{4'h2}};
    beats[2] = {16{4'h3}};
    beats[3] = {16{4'h4}};
    exp_line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    bus.address_i = 32'h0000_1234;
    bus.read_i    = 1'b1;
    tick();
    n_total++;
    if (bus.address_o !== 32'h0000_1220)
      $display("FAIL fill_address_o: got %h expected 00001220", bus.address_o);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if ({bus.read_o, bus.write_o, bus.resp_o} !== 3'b100)
        $display("FAIL fill_beat%0d_ctrl: got %b expected 100", k, {bus.read_o, bus.write_o, bus.resp_o});
      else n_pass++;
      bus.burst_i = beats[k];
      bus.resp_i  = 1'b1;
      tick();
    end
    bus.resp_i  = 1'b0;
    bus.burst_i = '0;
    n_total++;
    if ({bus.read_o, bus.resp_o} !== 2'b01)
      $display("FAIL fill_done_ctrl: got %b expected 01", {bus.read_o, bus.resp_o});
    else n_pass++;
    n_total++;
    if (bus.line_o !== exp_line) $display("FAIL fill_line_o: got %h expected %h", bus.line_o, exp_line);
    else n_pass++;
    bus.read_i = 1'b0;
    tick();
    n_total++;
    if ({bus.read_o, bus.resp_o} !== 2'b00)
      $display("FAIL fill_resp_single: got %b expected 00", {bus.read_o, bus.resp_o});
    else n_pass++;
    n_total++;
    if (bus.line_o !== exp_line) $display("FAIL fill_line_stable: got %h expected %h", bus.line_o, exp_line);
    else n_pass++;
  endtask

  task automatic test_writeback_stall();
    logic [63:0] exp_burst [7];
    logic        pat [7];
    exp_burst[0] = {16{4'hA}}; pat[0] = 1'b1;
    exp_burst[1] = {16{4'hB}}; pat[1] = 1'b0;
    exp_burst[2] = {16{4'hB}}; pat[2] = 1'b0;
    exp_burst[3] = {16{4'hB}}; pat[3] = 1'b1;
    exp_burst[4] = {16{4'hC}}; pat[4] = 1'b1;
    exp_burst[5] = {16{4'hD}}; pat[5] = 1'b0;
    exp_burst[6] = {16{4'hD}}; pat[6] = 1'b1;
    bus.line_i    = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
    bus.address_i = 32'h0000_2000;
    bus.write_i   = 1'b1;
    tick();
    bus.line_i = '0;
    n_total++;
    if (bus.address_o !== 32'h0000_2000)
      $display("FAIL wb_address_o: got %h expected 00002000", bus.address_o);
    else n_pass++;
    for (int i = 0; i < 7; i++) begin
      n_total++;
      if (bus.burst_o !== exp_burst[i])
        $display("FAIL wb_burst%0d: got %h expected %h", i, bus.burst_o, exp_burst[i]);
      else n_pass++;
      n_total++;
      if ({bus.write_o, bus.read_o, bus.resp_o} !== 3'b100)
        $display("FAIL wb_ctrl%0d: got %b expected 100", i, {bus.write_o, bus.read_o, bus.resp_o});
      else n_pass++;
      bus.resp_i = pat[i];
      tick();
    end
    bus.resp_i = 1'b0;
    n_total++;
    if ({bus.write_o, bus.resp_o} !== 2'b01)
      $display("FAIL wb_done_ctrl: got %b expected 01", {bus.write_o, bus.resp_o});
    else n_pass++;
    bus.write_i = 1'b0;
    tick();
    n_total++;
    if ({bus.write_o, bus.resp_o} !== 2'b00)
      $display("FAIL wb_resp_single: got %b expected 00", {bus.write_o, bus.resp_o});
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    logic [63:0]  beats [4];
    logic [255:0] exp_line;
    beats[0] = 64'h0102_0304_0506_0708;
    beats[1] = 64'h1112_1314_1516_1718;
    beats[2] = 64'h2122_2324_2526_2728;
    beats[3] = 64'h3132_3334_3536_3738;
    exp_line = {beats[3], beats[2], beats[1], beats[0]};
    bus.line_i    = {4{64'hFEED_FACE_0000_0001}};
    bus.address_i = 32'h8000_003F;
    bus.read_i    = 1'b1;
    bus.write_i   = 1'b1;
    tick();
    n_total++;
    if ({bus.write_o, bus.read_o} !== 2'b10)
      $display("FAIL sim_write_first: got %b expected 10", {bus.write_o, bus.read_o});
    else n_pass++;
    n_total++;
    if (bus.address_o !== 32'h8000_0020)
      $display("FAIL sim_address_o: got %h expected 80000020", bus.address_o);
    else n_pass++;
    bus.resp_i = 1'b1;
    repeat (4) tick();
    bus.resp_i = 1'b0;
    n_total++;
    if ({bus.write_o, bus.read_o, bus.resp_o} !== 3'b001)
      $display("FAIL sim_wr_done: got %b expected 001", {bus.write_o, bus.read_o, bus.resp_o});
    else n_pass++;
    bus.write_i = 1'b0;
    tick();
    n_total++;
    if ({bus.read_o, bus.resp_o} !== 2'b00)
      $display("FAIL sim_idle_gap: got %b expected 00", {bus.read_o, bus.resp_o});
    else n_pass++;
    tick();
    n_total++;
    if ({bus.read_o, bus.write_o} !== 2'b10)
      $display("FAIL sim_read_starts: got %b expected 10", {bus.read_o, bus.write_o});
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      bus.burst_i = beats[k];
      bus.resp_i  = 1'b1;
      tick();
    end
    bus.resp_i = 1'b0;
    n_total++;
    if (bus.resp_o !== 1'b1) $display("FAIL sim_rd_resp: got %b expected 1", bus.resp_o);
    else n_pass++;
    n_total++;
    if (bus.line_o !== exp_line) $display("FAIL sim_rd_line: got %h expected %h", bus.line_o, exp_line);
    else n_pass++;
    bus.read_i = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_fill();
    logic [255:0] exp_line;
    exp_line = {{16{4'hE}}, {16{4'h9}}, {16{4'h8}}, {16{4'h7}}};
    bus.address_i = 32'h0000_0040;
    bus.read_i    = 1'b1;
    tick();
    bus.resp_i  = 1'b1;
    bus.burst_i = {16{4'h5}};
    tick();
    bus.burst_i = {16{4'h6}};
    tick();
    bus.resp_i  = 1'b0;
    bus.read_i  = 1'b0;
    reset_n     = 1'b0;
    tick();
    n_total++;
    if ({bus.read_o, bus.resp_o} !== 2'b00)
      $display("FAIL rst_mid_ctrl: got %b expected 00", {bus.read_o, bus.resp_o});
    else n_pass++;
    n_total++;
    if ({bus.line_o, bus.address_o} !== 288'd0)
      $display("FAIL rst_mid_clear: got %h/%h expected 0/0", bus.line_o, bus.address_o);
    else n_pass++;
    reset_n = 1'b1;
    tick();
    n_total++;
    if ({bus.read_o, bus.write_o, bus.resp_o} !== 3'b000)
      $display("FAIL rst_mid_idle: got %b expected 000", {bus.read_o, bus.write_o, bus.resp_o});
    else n_pass++;
    bus.address_i = 32'hFFFF_FFFF;
    bus.read_i    = 1'b1;
    tick();
    n_total++;
    if ({bus.read_o, bus.address_o} !== {1'b1, 32'hFFFF_FFE0})
      $display("FAIL rst_new_start: got %b/%h expected 1/ffffffe0", bus.read_o, bus.address_o);
    else n_pass++;
    bus.resp_i = 1'b1;
    bus.burst_i = {16{4'h7}}; tick();
    bus.burst_i = {16{4'h8}}; tick();
    bus.burst_i = {16{4'h9}}; tick();
    bus.burst_i = {16{4'hE}}; tick();
    bus.resp_i = 1'b0;
    n_total++;
    if ({bus.read_o, bus.resp_o} !== 2'b01)
      $display("FAIL rst_new_done: got %b expected 01", {bus.read_o, bus.resp_o});
    else n_pass++;
    n_total++;
    if (bus.line_o !== exp_line) $display("FAIL rst_new_line: got %h expected %h", bus.line_o, exp_line);
    else n_pass++;
    bus.read_i = 1'b0;
    tick();
  endtask

  task automatic test_hold_through_done();
    logic         pat [7];
    logic [63:0]  beats [4];
    logic [255:0] old_line;
    logic [255:0] exp_line;
    int           nb;
    pat[0] = 1'b0; pat[1] = 1'b1; pat[2] = 1'b0; pat[3] = 1'b1;
    pat[4] = 1'b1; pat[5] = 1'b0; pat[6] = 1'b1;
    beats[0] = 64'hA0A0_0000_0000_000A;
    beats[1] = 64'hB1B1_1111_0000_000B;
    beats[2] = 64'hC2C2_2222_0000_000C;
    beats[3] = 64'hD3D3_3333_0000_000D;
    old_line = {{16{4'hE}}, {16{4'h9}}, {16{4'h8}}, {16{4'h7}}};
    exp_line = {beats[3], beats[2], beats[1], beats[0]};
    nb = 0;
    bus.address_i = 32'h0000_0100;
    bus.read_i    = 1'b1;
    tick();
    n_total++;
    if (bus.line_o !== old_line)
      $display("FAIL hold_line_before_beat: got %h expected %h", bus.line_o, old_line);
    else n_pass++;
    for (int i = 0; i < 7; i++) begin
      n_total++;
      if ({bus.read_o, bus.resp_o} !== 2'b10)
        $display("FAIL hold_ctrl%0d: got %b expected 10", i, {bus.read_o, bus.resp_o});
      else n_pass++;
      bus.resp_i  = pat[i];
      bus.burst_i = pat[i] ? beats[nb] : 64'hDEAD_BEEF_DEAD_BEEF;
      if (pat[i]) nb++;
      tick();
    end
    bus.resp_i = 1'b0;
    n_total++;
    if ({bus.read_o, bus.resp_o} !== 2'b01)
      $display("FAIL hold_done: got %b expected 01", {bus.read_o, bus.resp_o});
    else n_pass++;
    n_total++;
    if (bus.line_o !== exp_line) $display("FAIL hold_line: got %h expected %h", bus.line_o, exp_line);
    else n_pass++;
    bus.read_i = 1'b0;
    for (int j = 0; j < 2; j++) begin
      tick();
      n_total++;
      if ({bus.read_o, bus.write_o, bus.resp_o} !== 3'b000)
        $display("FAIL hold_idle%0d: got %b expected 000", j, {bus.read_o, bus.write_o, bus.resp_o});
      else n_pass++;
    end
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_fill();
    test_writeback_stall();
    test_simultaneous();
    test_reset_mid_fill();
    test_hold_through_done();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
